// File: rtl/rf_scoreboard.sv
// rf_scoreboard: 32x32 GPR file with write-through bypass and per-register
// pending-write counters that drive the decode-side RAW ready flags.
// Latency: reads and ready flags are combinational (0 cycles); writes and
// counter updates take effect on the next rising edge of clk.
// Backpressure: none; the write bus and the issue strobe are accepted every cycle.
//
// Ports:
//   clk, reset           clock and asynchronous active-high reset
//   ws_to_rf_bus[37:0]   {rf_we, rf_waddr[4:0], rf_wdata[31:0]} from write-back
//   ds_issue_valid/dest  instruction leaving decode and its destination (0 = none)
//   raddr1/2             read addresses
//   rdata1/2             read data (bypassed from the write bus)
//   rready1/2            operand has no outstanding write
//   pend_err             sticky counter overflow/underflow flag
module rf_scoreboard #(
    parameter int PEND_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [37:0] ws_to_rf_bus,
    input  logic        ds_issue_valid,
    input  logic [4:0]  ds_issue_dest,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic        rready1,
    output logic        rready2,
    output logic        pend_err
);

    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ZERO = '0;
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    assign {rf_we, rf_waddr, rf_wdata} = ws_to_rf_bus;

    // r0 is never written and never tracked.
    logic wr;
    logic iss;
    assign wr  = rf_we && (rf_waddr != 5'd0);
    assign iss = ds_issue_valid && (ds_issue_dest != 5'd0);

    logic [31:0] inc_vec;
    logic [31:0] dec_vec;
    assign inc_vec = iss ? (32'd1 << ds_issue_dest) : 32'd0;
    assign dec_vec = wr  ? (32'd1 << rf_waddr)      : 32'd0;

    logic [31:0]       regs_q [32];
    logic [PEND_W-1:0] pend_q [32];
    logic [PEND_W-1:0] pend_d [32];
    logic              pend_err_q;
    logic              pend_err_d;

    // Counter next-state. A simultaneous issue and retire cancel out, so the
    // boundary cases only apply when exactly one of them targets a register.
    always_comb begin
        pend_err_d = pend_err_q;
        for (int i = 0; i < 32; i++) begin
            pend_d[i] = pend_q[i];
            if (inc_vec[i] && !dec_vec[i]) begin
                if (pend_q[i] == PEND_MAX) begin
                    pend_err_d = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + PEND_ONE;
                end
            end else if (dec_vec[i] && !inc_vec[i]) begin
                if (pend_q[i] == PEND_ZERO) begin
                    pend_err_d = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] - PEND_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
                pend_q[i] <= PEND_ZERO;
            end
            pend_err_q <= 1'b0;
        end else begin
            // Data is written even when the counter underflows.
            if (wr) begin
                regs_q[rf_waddr] <= rf_wdata;
            end
            for (int i = 0; i < 32; i++) begin
                pend_q[i] <= pend_d[i];
            end
            pend_err_q <= pend_err_d;
        end
    end

    assign pend_err = pend_err_q;

    // Read port 1
    always_comb begin
        rdata1  = regs_q[raddr1];
        rready1 = 1'b0;
        if (raddr1 == 5'd0) begin
            rdata1  = 32'd0;
            rready1 = 1'b1;
        end else begin
            if (wr && (rf_waddr == raddr1)) begin
                rdata1 = rf_wdata;
            end
            // The last outstanding write retiring this cycle makes the operand
            // available through the bypass.
            if (pend_q[raddr1] == PEND_ZERO) begin
                rready1 = 1'b1;
            end else if ((pend_q[raddr1] == PEND_ONE) && wr && (rf_waddr == raddr1)) begin
                rready1 = 1'b1;
            end
        end
    end

    // Read port 2
    always_comb begin
        rdata2  = regs_q[raddr2];
        rready2 = 1'b0;
        if (raddr2 == 5'd0) begin
            rdata2  = 32'd0;
            rready2 = 1'b1;
        end else begin
            if (wr && (rf_waddr == raddr2)) begin
                rdata2 = rf_wdata;
            end
            if (pend_q[raddr2] == PEND_ZERO) begin
                rready2 = 1'b1;
            end else if ((pend_q[raddr2] == PEND_ONE) && wr && (rf_waddr == raddr2)) begin
                rready2 = 1'b1;
            end
        end
    end

endmodule
